// File: rtl/aexm_sched_pkg.sv
// Shared definitions for the AEXM pipeline scheduler: state encoding and refill side select.
package aexm_sched_pkg;

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_IMISS = 3'd1,
        ST_DMISS = 3'd2,
        ST_MULW  = 3'd3,
        ST_DIVW  = 3'd4
    } sched_state_e;

    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

endpackage

// File: rtl/aexm_stall_cnt.sv
// Loadable down-counter with ==1 detect; times the MUL and DIV execute stalls.
module aexm_stall_cnt #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_one
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign is_one = (cnt_reg == CNT_W'(1));

endmodule

// File: rtl/aexm_pipe_sched.sv
// AEXM pipeline scheduler: stalls decode/execute on cache misses and multi-cycle ops,
// and sequences the shared refill port (data side served before instruction side).
module aexm_pipe_sched
    import aexm_sched_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic       gclk,
    input  logic       grst,
    input  logic       i_hit,
    input  logic       x_strlod,
    input  logic       d_hit,
    input  logic       d_force_miss,
    input  logic       x_mul,
    input  logic       x_div,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_sel,
    output logic       d_en,
    output logic       x_en,
    output logic       busy,
    output logic [2:0] state_o
);

    localparam logic DIV_MULTI  = (DIV_LAT >= 2);
    localparam logic DIV_SINGLE = (DIV_LAT == 1);
    localparam logic MUL_MULTI  = (MUL_LAT >= 2);
    localparam logic MUL_SINGLE = (MUL_LAT == 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'((DIV_LAT >= 2) ? DIV_LAT - 1 : 0);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_LAT >= 2) ? MUL_LAT - 1 : 0);

    sched_state_e     state_reg, state_next;
    logic             done_reg, done_next;
    logic             mem_req_reg, mem_req_next;
    logic             mem_sel_reg, mem_sel_next;
    logic             cnt_load, cnt_dec, cnt_is_one;
    logic [CNT_W-1:0] cnt_val;
    logic             run_en;
    logic             dmiss;

    aexm_stall_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk      (gclk),
        .rst_n    (grst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .is_one   (cnt_is_one)
    );

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            state_reg   <= ST_RUN;
            done_reg    <= 1'b0;
            mem_req_reg <= 1'b0;
            mem_sel_reg <= SEL_I;
        end else begin
            state_reg   <= state_next;
            done_reg    <= done_next;
            mem_req_reg <= mem_req_next;
            mem_sel_reg <= mem_sel_next;
        end
    end

    assign dmiss = x_strlod & (~d_hit | d_force_miss) & ~done_reg;

    always_comb begin
        state_next   = state_reg;
        done_next    = done_reg;
        mem_req_next = mem_req_reg;
        mem_sel_next = mem_sel_reg;
        cnt_load     = 1'b0;
        cnt_val      = '0;
        cnt_dec      = 1'b0;
        run_en       = 1'b0;
        unique case (state_reg)
            ST_RUN: begin
                if (dmiss) begin
                    state_next   = ST_DMISS;
                    mem_req_next = 1'b1;
                    mem_sel_next = SEL_D;
                end else if (x_div && !done_reg && DIV_MULTI) begin
                    state_next = ST_DIVW;
                    cnt_load   = 1'b1;
                    cnt_val    = DIV_LOAD;
                end else if (x_div && !done_reg && DIV_SINGLE) begin
                    done_next = 1'b1;
                end else if (x_mul && !done_reg && MUL_MULTI) begin
                    state_next = ST_MULW;
                    cnt_load   = 1'b1;
                    cnt_val    = MUL_LOAD;
                end else if (x_mul && !done_reg && MUL_SINGLE) begin
                    done_next = 1'b1;
                end else if (!i_hit) begin
                    state_next   = ST_IMISS;
                    mem_req_next = 1'b1;
                    mem_sel_next = SEL_I;
                end else begin
                    run_en    = 1'b1;
                    done_next = 1'b0;
                end
            end
            ST_MULW, ST_DIVW: begin
                if (cnt_is_one) begin
                    state_next = ST_RUN;
                    done_next  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_IMISS, ST_DMISS: begin
                // Only a data refill retires the execute instruction.
                if (mem_ack) begin
                    state_next   = ST_RUN;
                    mem_req_next = 1'b0;
                    if (state_reg == ST_DMISS) begin
                        done_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // State sits at RUN during reset, so the enables must be masked explicitly.
    assign d_en    = run_en & grst;
    assign x_en    = run_en & grst;
    assign mem_req = mem_req_reg;
    assign mem_sel = mem_sel_reg;
    assign busy    = (state_reg != ST_RUN);
    assign state_o = state_reg;

endmodule

// File: tb/tb_aexm_pipe_sched.sv
// Scoreboard bench for aexm_pipe_sched: a stall-budget reference model predicts every cycle.
module tb_aexm_pipe_sched;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 32;

    logic gclk = 1'b0;
    logic grst = 1'b0;
    logic i_hit = 1'b0, x_strlod = 1'b0, d_hit = 1'b0, d_force_miss = 1'b0;
    logic x_mul = 1'b0, x_div = 1'b0, mem_ack = 1'b0;
    logic mem_req, mem_sel, d_en, x_en, busy;
    logic [2:0] state_o;

    aexm_pipe_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
        .gclk(gclk), .grst(grst), .i_hit(i_hit), .x_strlod(x_strlod), .d_hit(d_hit),
        .d_force_miss(d_force_miss), .x_mul(x_mul), .x_div(x_div), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_sel(mem_sel), .d_en(d_en), .x_en(x_en), .busy(busy),
        .state_o(state_o)
    );

    always #5 gclk = ~gclk;

    typedef struct {
        int   cyc;
        logic req;
        logic sel;
        logic en;
        logic [2:0] st;
        logic bsy;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Reference model: outstanding refill, remaining op-stall budget, retired flag.
    bit m_refill = 0;
    bit m_side = 0;
    int m_wait = 0;
    bit m_wait_div = 0;
    bit m_retired = 0;

    task automatic check(input string name, input int c, input logic [7:0] act, input logic [7:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, req);
        end
    endtask

    function automatic bit start_op(input int lat, input bit is_div);
        if (lat == 0) return 0;
        if (lat == 1) m_retired = 1;
        else begin
            m_wait = lat - 1;
            m_wait_div = is_div;
        end
        return 1;
    endfunction

    task automatic model_step(input bit rst_n, input bit ih, input bit sl, input bit dh, input bit fm,
                              input bit mu, input bit dv, input bit ak, output exp_t e);
        e.cyc = cyc;
        if (!rst_n) begin
            m_refill = 0; m_side = 0; m_wait = 0; m_wait_div = 0; m_retired = 0;
            e.req = 0; e.sel = 0; e.en = 0; e.st = 3'd0; e.bsy = 0;
            return;
        end
        e.req = m_refill;
        e.sel = m_side;
        e.en  = 0;
        e.st  = m_refill ? (m_side ? 3'd2 : 3'd1) : (m_wait > 0 ? (m_wait_div ? 3'd4 : 3'd3) : 3'd0);
        e.bsy = (e.st != 3'd0);
        if (m_refill) begin
            if (ak) begin
                m_refill = 0;
                if (m_side) m_retired = 1;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_retired = 1;
        end else if (sl && (!dh || fm) && !m_retired) begin
            m_refill = 1; m_side = 1;
        end else if (dv && !m_retired && start_op(DIV_LAT, 1)) begin
        end else if (mu && !m_retired && start_op(MUL_LAT, 0)) begin
        end else if (!ih) begin
            m_refill = 1; m_side = 0;
        end else begin
            e.en = 1;
            m_retired = 0;
        end
    endtask

    task automatic cycle(input bit rst_n, input bit ih, input bit sl, input bit dh, input bit fm,
                         input bit mu, input bit dv, input bit ak);
        exp_t e;
        @(posedge gclk);
        #1;
        cyc++;
        grst = rst_n; i_hit = ih; x_strlod = sl; d_hit = dh; d_force_miss = fm;
        x_mul = mu; x_div = dv; mem_ack = ak;
        #1;
        if (!rst_n) check("async_req_drop", cyc, {7'd0, mem_req}, 8'd0);
        model_step(rst_n, ih, sl, dh, fm, mu, dv, ak, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1, 1, 0, 1, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle presents a full output vector; compare it against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge gclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mem_req", e.cyc, {7'd0, mem_req}, {7'd0, e.req});
                check("mem_sel", e.cyc, {7'd0, mem_sel}, {7'd0, e.sel});
                check("x_en", e.cyc, {7'd0, x_en}, {7'd0, e.en});
                check("d_en", e.cyc, {7'd0, d_en}, {7'd0, e.en});
                check("state_o", e.cyc, {5'd0, state_o}, {5'd0, e.st});
                check("busy", e.cyc, {7'd0, busy}, {7'd0, e.bsy});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with random inputs, then release into a clean RUN cycle.
        for (int k = 0; k < 4; k++)
            cycle(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
        idle(2);

        // D-miss with ack after 5 stalled cycles; d_hit stays low afterwards.
        for (int k = 0; k < 5; k++) cycle(1, 1, 1, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 0, 0, 1);
        cycle(1, 1, 1, 0, 0, 0, 0, 0);
        idle(2);

        // DIV then MUL held.
        for (int k = 0; k < DIV_LAT + 2; k++) cycle(1, 1, 0, 1, 0, 0, 1, 0);
        idle(1);
        for (int k = 0; k < MUL_LAT + 2; k++) cycle(1, 1, 0, 1, 0, 1, 0, 0);
        idle(1);

        // Simultaneous D and I miss: data first, then instruction.
        for (int k = 0; k < 3; k++) cycle(1, 0, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) cycle(1, 0, 1, 0, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0, 0, 1);
        cycle(1, 1, 1, 0, 0, 0, 0, 0);
        idle(2);

        // Forced miss on a hitting load.
        cycle(1, 1, 1, 1, 1, 0, 0, 0);
        cycle(1, 1, 1, 1, 1, 0, 0, 0);
        cycle(1, 1, 1, 1, 1, 0, 0, 1);
        cycle(1, 1, 1, 1, 1, 0, 0, 0);
        idle(2);

        // Stray ack in RUN is ignored.
        cycle(1, 1, 0, 1, 0, 0, 0, 1);

        // Reset three cycles into a D-miss.
        for (int k = 0; k < 4; k++) cycle(1, 1, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 0, 0, 0);
        idle(3);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 9) > 1),
                  ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 2),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) == 0));
        end
        idle(2);

        @(negedge gclk);
        @(posedge gclk);
        if (exp_q.size() != 0) check("queue_drain", cyc, 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
